// File: rtl/rpn_button_pulser.sv
// rtl/rpn_button_pulser.sv - Enter/Undo button synchronizer, debounce and pulse generator
// Two-flop sync + per-button press/release FSM; long Undo hold raises Clear_pulse.
module rpn_button_pulser #(
   parameter int DEBOUNCE_CYCLES   = 10,
   parameter int LONG_PRESS_CYCLES = 50,
   localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enter_btn,
   input  logic       undo_btn,
   output logic       Enter_pulse,
   output logic       Undo_pulse,
   output logic       Clear_pulse,
   output logic [1:0] btn_level
);

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } btnState_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DEB  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_PRESS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(LONG_PRESS_CYCLES - 1);

   // index 0 = Enter, index 1 = Undo
   logic [1:0]       sync1, sync2;
   btnState_t        state [2];
   btnState_t        stateNext [2];
   logic [CNT_W-1:0] cnt [2];
   logic [CNT_W-1:0] cntNext [2];
   logic [CNT_W-1:0] holdCnt, holdNext;
   logic [1:0]       pressReq, levelNext;
   logic             clearReq;
   logic             enterNext, undoNext;

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         stateNext[b] = state[b];
         cntNext[b]   = cnt[b];
         pressReq[b]  = 1'b0;
         levelNext[b] = btn_level[b];
         case (state[b])
            RELEASED: begin
               if (sync2[b]) begin
                  stateNext[b] = ARM_PRESS;
                  cntNext[b]   = CNT_ONE;
               end
            end
            ARM_PRESS: begin
               if (!sync2[b]) begin
                  stateNext[b] = RELEASED;
                  cntNext[b]   = '0;
               end else if (cnt[b] == CNT_DEB) begin
                  stateNext[b] = PRESSED;
                  cntNext[b]   = '0;
                  levelNext[b] = 1'b1;
                  pressReq[b]  = 1'b1;
               end else begin
                  cntNext[b] = cnt[b] + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!sync2[b]) begin
                  stateNext[b] = ARM_RELEASE;
                  cntNext[b]   = CNT_ONE;
               end
            end
            default: begin
               if (sync2[b]) begin
                  stateNext[b] = PRESSED;
                  cntNext[b]   = '0;
               end else if (cnt[b] == CNT_DEB) begin
                  stateNext[b] = RELEASED;
                  cntNext[b]   = '0;
                  levelNext[b] = 1'b0;
               end else begin
                  cntNext[b] = cnt[b] + CNT_ONE;
               end
            end
         endcase
      end
   end

   // Hold counter survives ARM_RELEASE->PRESSED bounces so Clear fires once per press.
   always_comb begin
      holdNext = holdCnt;
      clearReq = 1'b0;
      if (state[1] == PRESSED || state[1] == ARM_RELEASE) begin
         if (holdCnt != CNT_LONG) begin
            holdNext = holdCnt + CNT_ONE;
            clearReq = (holdCnt == CNT_FIRE);
         end
      end
      if (stateNext[1] == RELEASED || state[1] == ARM_PRESS) begin
         holdNext = '0;
      end
   end

   always_comb begin
      enterNext = pressReq[0] & ~clearReq;
      undoNext  = pressReq[1] & ~pressReq[0] & ~clearReq;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1       <= '0;
         sync2       <= '0;
         holdCnt     <= '0;
         btn_level   <= '0;
         Enter_pulse <= 1'b0;
         Undo_pulse  <= 1'b0;
         Clear_pulse <= 1'b0;
         for (int b = 0; b < 2; b++) begin
            state[b] <= RELEASED;
            cnt[b]   <= '0;
         end
      end else begin
         sync1       <= {undo_btn, enter_btn};
         sync2       <= sync1;
         holdCnt     <= holdNext;
         btn_level   <= levelNext;
         Enter_pulse <= enterNext;
         Undo_pulse  <= undoNext;
         Clear_pulse <= clearReq;
         for (int b = 0; b < 2; b++) begin
            state[b] <= stateNext[b];
            cnt[b]   <= cntNext[b];
         end
      end
   end

endmodule

// File: tb/tb_rpn_button_pulser.sv
// tb/tb_rpn_button_pulser.sv - randomized and directed bench for rpn_button_pulser
// Reference model: run-length debounce on the 2-cycle delayed raw input plus hold-edge count.
module tb_rpn_button_pulser;

   localparam int D = 4;
   localparam int L = 20;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enter_btn = 1'b0;
   logic       undo_btn = 1'b0;
   logic       Enter_pulse, Undo_pulse, Clear_pulse;
   logic [1:0] btn_level;

   always #5 clock = ~clock;

   rpn_button_pulser #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
      .clock       (clock),
      .reset       (reset),
      .enter_btn   (enter_btn),
      .undo_btn    (undo_btn),
      .Enter_pulse (Enter_pulse),
      .Undo_pulse  (Undo_pulse),
      .Clear_pulse (Clear_pulse),
      .btn_level   (btn_level)
   );

   int errCount = 0;
   int checkCount = 0;

   bit [1:0] h1, h2, lvl;
   int       run [2];
   int       held;
   bit       mE, mU, mC;

   int stepIdx, dutE, dutU, dutC, enterAt, undoAt, clearAt;

   task automatic checkVal(input string tag, input int got, input int exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      h1 = '0; h2 = '0; lvl = '0;
      run[0] = 0; run[1] = 0; held = 0;
      mE = 1'b0; mU = 1'b0; mC = 1'b0;
   endtask

   task automatic modelEdge(input bit e, input bit u);
      bit [1:0] samp;
      bit [1:0] press;
      bit       preUndo;
      samp    = h2;
      h2      = h1;
      h1      = {u, e};
      preUndo = lvl[1];
      press   = '0;
      for (int b = 0; b < 2; b++) begin
         if (samp[b] != lvl[b]) begin
            run[b]++;
            if (run[b] == D + 1) begin
               lvl[b]   = samp[b];
               run[b]   = 0;
               press[b] = samp[b];
            end
         end else begin
            run[b] = 0;
         end
      end
      mC = 1'b0;
      if (preUndo && held < L) begin
         held++;
         if (held == L) mC = 1'b1;
      end
      if (!lvl[1]) held = 0;
      mE = press[0] & ~mC;
      mU = press[1] & ~press[0] & ~mC;
   endtask

   task automatic clearStats();
      stepIdx = 0; dutE = 0; dutU = 0; dutC = 0;
      enterAt = 0; undoAt = 0; clearAt = 0;
   endtask

   task automatic step(input bit e, input bit u, input bit r);
      @(negedge clock);
      enter_btn = e;
      undo_btn  = u;
      reset     = r;
      @(posedge clock);
      if (r) modelReset();
      else modelEdge(e, u);
      #1;
      stepIdx++;
      checkVal("outputs", int'({btn_level, Clear_pulse, Undo_pulse, Enter_pulse}),
               int'({lvl, mC, mU, mE}));
      checkVal("onehot", int'($countones({Clear_pulse, Undo_pulse, Enter_pulse}) <= 1), 1);
      dutE += int'(Enter_pulse);
      dutU += int'(Undo_pulse);
      dutC += int'(Clear_pulse);
      if (Enter_pulse && enterAt == 0) enterAt = stepIdx;
      if (Undo_pulse && undoAt == 0) undoAt = stepIdx;
      if (Clear_pulse && clearAt == 0) clearAt = stepIdx;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic asyncReset();
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checkVal("async_reset_outputs",
               int'({btn_level, Clear_pulse, Undo_pulse, Enter_pulse}), 0);
      modelReset();
   endtask

   int       remain [2];
   bit [1:0] rawLvl;

   initial begin
      modelReset();
      clearStats();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      checkVal("reset_state", int'({btn_level, Clear_pulse, Undo_pulse, Enter_pulse}), 0);
      idle(5);

      // single clean Enter press
      clearStats();
      for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
      idle(12);
      checkVal("t1_enter_count", dutE, 1);
      checkVal("t1_enter_step", enterAt, 7);

      // short bounce only
      clearStats();
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0);
      idle(12);
      checkVal("t2_enter_count", dutE, 0);

      // simultaneous press: Enter wins
      clearStats();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
      checkVal("t3_level", int'(btn_level), 3);
      idle(12);
      checkVal("t3_enter_count", dutE, 1);
      checkVal("t3_undo_count", dutU, 0);

      // long Undo hold
      clearStats();
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
      idle(12);
      checkVal("t4_undo_count", dutU, 1);
      checkVal("t4_clear_count", dutC, 1);
      checkVal("t4_clear_delay", clearAt - undoAt, L);

      // release glitch while pressed
      clearStats();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      checkVal("t5_level", int'(btn_level[0]), 1);
      idle(12);
      checkVal("t5_enter_count", dutE, 1);

      // reset during ARM_PRESS, released before reset deasserts
      clearStats();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      asyncReset();
      step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
      idle(20);
      checkVal("t6_enter_count", dutE, 0);

      // reset while pressed, held through release -> new press
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      asyncReset();
      step(1'b1, 1'b0, 1'b1);
      clearStats();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
      checkVal("t7_enter_step", enterAt, 7);
      idle(12);

      // randomized traffic against the model
      clearStats();
      remain[0] = 0; remain[1] = 0; rawLvl = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 2; b++) begin
            if (remain[b] == 0) begin
               rawLvl[b] = ~rawLvl[b];
               remain[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                                       : $urandom_range(1, 8);
            end
            remain[b]--;
         end
         step(rawLvl[0], rawLvl[1], ($urandom_range(0, 699) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
